// File: rtl/expr_checker_n_if.sv
// Character stream into the expression checker and its status back out.
// master = character source, slave = checker.
interface expr_checker_n_if #(
  parameter int unsigned DW = 3
);
  logic          restart;
  logic          in_valid;
  logic [7:0]    in;
  logic          out;
  logic          err;
  logic [DW-1:0] depth;

  modport master (
    output restart, in_valid, in,
    input  out, err, depth
  );

  modport slave (
    input  restart, in_valid, in,
    output out, err, depth
  );
endinterface

// File: rtl/expr_checker_n.sv
// Streaming syntax checker for arithmetic expressions, one ASCII character per cycle.
// Supports multi-digit numbers, bounded parenthesis nesting, a configurable operator
// set and optional space skipping. Errors are sticky until clr or restart.
module expr_checker_n #(
  parameter int unsigned MAX_DEPTH  = 7,
  parameter int unsigned MAX_DIGITS = 4,
  parameter logic [3:0]  OP_MASK    = 4'b0101,
  parameter bit          SKIP_WS    = 1'b1
) (
  input logic            clk,
  input logic            clr,
  expr_checker_n_if.slave bus
);

  localparam int unsigned DW = $clog2(MAX_DEPTH + 1);
  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
  localparam logic [DW-1:0] DepthMax = DW'(MAX_DEPTH);
  localparam logic [CW-1:0] CntMax   = CW'(MAX_DIGITS);

  typedef enum logic [1:0] {StOpnd, StNum, StClose, StErr} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, err_q;

  logic is_digit, is_open, is_close, is_space, is_op;

  // Classify the incoming character; disabled operators count as unknown.
  always_comb begin
    is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    is_open  = (bus.in == 8'h28);
    is_close = (bus.in == 8'h29);
    is_space = (bus.in == 8'h20);
    is_op    = 1'b0;
    case (bus.in)
      8'h2B:   is_op = OP_MASK[0];
      8'h2D:   is_op = OP_MASK[1];
      8'h2A:   is_op = OP_MASK[2];
      8'h2F:   is_op = OP_MASK[3];
      default: is_op = 1'b0;
    endcase
  end

  // Next-state: anything not explicitly legal in the current state falls into StErr,
  // and depth/count are left untouched on that transition so they freeze.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    cnt_d   = cnt_q;
    if (bus.restart) begin
      state_d = StOpnd;
      depth_d = '0;
      cnt_d   = '0;
    end else if (bus.in_valid && (state_q != StErr) && !(is_space && SKIP_WS)) begin
      state_d = StErr;
      unique case (state_q)
        StOpnd: begin
          if (is_digit) begin
            state_d = StNum;
            cnt_d   = CW'(1);
          end else if (is_open && (depth_q != DepthMax)) begin
            state_d = StOpnd;
            depth_d = depth_q + DW'(1);
          end
        end
        StNum, StClose: begin
          if (is_digit && (state_q == StNum)) begin
            if (cnt_q != CntMax) begin
              state_d = StNum;
              cnt_d   = cnt_q + CW'(1);
            end
          end else if (is_op) begin
            state_d = StOpnd;
            cnt_d   = '0;
          end else if (is_close && (depth_q != '0)) begin
            state_d = StClose;
            depth_d = depth_q - DW'(1);
          end
        end
        default: state_d = StErr;
      endcase
    end
  end

  // State and registered outputs; outputs reflect the character consumed on this edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StOpnd;
      depth_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      cnt_q   <= cnt_d;
      out_q   <= ((state_d == StNum) || (state_d == StClose)) && (depth_d == '0);
      err_q   <= (state_d == StErr);
    end
  end

  assign bus.out   = out_q;
  assign bus.err   = err_q;
  assign bus.depth = depth_q;

endmodule

// File: tb/tb_expr_checker_n.sv
// Bench for expr_checker_n: instance A uses default parameters, instance B uses
// MAX_DEPTH=2, all operators enabled and SKIP_WS=0.
module tb_expr_checker_n;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  expr_checker_n_if #(.DW(3)) ia ();
  expr_checker_n_if #(.DW(2)) ib ();

  expr_checker_n dut_a (
    .clk (clk),
    .clr (clr),
    .bus (ia)
  );

  expr_checker_n #(
    .MAX_DEPTH  (2),
    .MAX_DIGITS (4),
    .OP_MASK    (4'b1111),
    .SKIP_WS    (1'b0)
  ) dut_b (
    .clk (clk),
    .clr (clr),
    .bus (ib)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: grammar-level view of what has been read so far.
  int       p_maxd[2] = '{7, 2};
  int       p_maxg[2] = '{4, 4};
  bit [3:0] p_mask[2] = '{4'b0101, 4'b1111};
  bit       p_skip[2] = '{1'b1, 1'b0};

  int m_need[2];   // 0: an operand must come next, 1: reading a number, 2: just closed ')'
  int m_open[2];   // unmatched '(' count
  int m_len[2];    // digits in the current number
  bit m_bad[2];

  function automatic void mreset(int w);
    m_need[w] = 0;
    m_open[w] = 0;
    m_len[w]  = 0;
    m_bad[w]  = 1'b0;
  endfunction

  function automatic bit op_enabled(int w, byte c);
    case (c)
      "+":     return p_mask[w][0];
      "-":     return p_mask[w][1];
      "*":     return p_mask[w][2];
      "/":     return p_mask[w][3];
      default: return 1'b0;
    endcase
  endfunction

  function automatic void mstep(int w, byte c);
    if (m_bad[w]) return;
    if (c == " " && p_skip[w]) return;
    if (c >= "0" && c <= "9") begin
      if (m_need[w] == 0) begin
        m_need[w] = 1;
        m_len[w]  = 1;
      end else if (m_need[w] == 1 && m_len[w] < p_maxg[w]) m_len[w]++;
      else m_bad[w] = 1'b1;
    end else if (c == "(") begin
      if (m_need[w] == 0 && m_open[w] < p_maxd[w]) m_open[w]++;
      else m_bad[w] = 1'b1;
    end else if (op_enabled(w, c)) begin
      if (m_need[w] != 0) begin
        m_need[w] = 0;
        m_len[w]  = 0;
      end else m_bad[w] = 1'b1;
    end else if (c == ")") begin
      if (m_need[w] != 0 && m_open[w] > 0) begin
        m_open[w]--;
        m_need[w] = 2;
      end else m_bad[w] = 1'b1;
    end else begin
      m_bad[w] = 1'b1;
    end
  endfunction

  // Packed {out, err, depth[7:0]} expected from the model.
  function automatic logic [9:0] mexp(int w);
    bit o;
    o = !m_bad[w] && (m_need[w] != 0) && (m_open[w] == 0);
    return {o, m_bad[w], 8'(m_open[w])};
  endfunction

  function automatic logic [9:0] obs(int w);
    if (w == 0) return {ia.out, ia.err, 5'b0, ia.depth};
    return {ib.out, ib.err, 6'b0, ib.depth};
  endfunction

  task automatic drive(int w, bit rs, bit v, byte c);
    if (w == 0) begin
      ia.restart = rs; ia.in_valid = v; ia.in = c;
    end else begin
      ib.restart = rs; ib.in_valid = v; ib.in = c;
    end
    @(posedge clk);
    #1;
    ia.restart = 1'b0; ia.in_valid = 1'b0;
    ib.restart = 1'b0; ib.in_valid = 1'b0;
    if (rs) mreset(w);
    else if (v) mstep(w, c);
  endtask

  task automatic feed(int w, byte c);
    drive(w, 1'b0, 1'b1, c);
  endtask

  task automatic restart(int w);
    drive(w, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_reset;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    mreset(0);
    mreset(1);
    n_tests++;
    if (ia.out !== 1'b0) begin n_fail++; $display("FAIL reset_out_a: got %b want 0", ia.out); end
    n_tests++;
    if (ia.err !== 1'b0) begin n_fail++; $display("FAIL reset_err_a: got %b want 0", ia.err); end
    n_tests++;
    if (ia.depth !== 3'd0) begin n_fail++; $display("FAIL reset_depth_a: got %0d want 0", ia.depth); end
    n_tests++;
    if (obs(1) !== 10'd0) begin n_fail++; $display("FAIL reset_b: got %h want 000", obs(1)); end
  endtask

  task automatic test_defaults;
    string s = "1+(1+2)*(1*3) ";
    bit exp_o[14] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};
    int peak = 0;
    for (int i = 0; i < s.len(); i++) begin
      feed(0, s[i]);
      if (int'(ia.depth) > peak) peak = int'(ia.depth);
      n_tests++;
      if (ia.out !== exp_o[i]) begin
        n_fail++; $display("FAIL defaults_out[%0d]: got %b want %b", i, ia.out, exp_o[i]);
      end
      n_tests++;
      if (obs(0) !== mexp(0)) begin
        n_fail++; $display("FAIL defaults_model[%0d]: got %h want %h", i, obs(0), mexp(0));
      end
    end
    n_tests++;
    if (peak != 1) begin n_fail++; $display("FAIL defaults_peak: got %0d want 1", peak); end
    n_tests++;
    if (ia.err !== 1'b0 || ia.depth !== 3'd0) begin
      n_fail++; $display("FAIL defaults_end: got err=%b depth=%0d want 0/0", ia.err, ia.depth);
    end
  endtask

  task automatic test_multidigit;
    string s1 = "1234+56";
    string s2 = "123456";
    bit o1[7] = '{1, 1, 1, 1, 0, 1, 1};
    bit o2[6] = '{1, 1, 1, 1, 0, 0};
    bit e2[6] = '{0, 0, 0, 0, 1, 1};
    restart(0);
    for (int i = 0; i < s1.len(); i++) begin
      feed(0, s1[i]);
      n_tests++;
      if (ia.out !== o1[i] || obs(0) !== mexp(0)) begin
        n_fail++; $display("FAIL multidigit[%0d]: got %h want out=%b %h", i, obs(0), o1[i], mexp(0));
      end
    end
    restart(0);
    for (int i = 0; i < s2.len(); i++) begin
      feed(0, s2[i]);
      n_tests++;
      if (ia.out !== o2[i] || ia.err !== e2[i] || obs(0) !== mexp(0)) begin
        n_fail++;
        $display("FAIL digit_limit[%0d]: got out=%b err=%b want %b/%b", i, ia.out, ia.err, o2[i], e2[i]);
      end
    end
  endtask

  task automatic test_nesting;
    string s1 = "((1))";
    string s2 = "(((";
    int d1[5] = '{1, 2, 2, 1, 0};
    bit o1[5] = '{0, 0, 0, 0, 1};
    int d2[3] = '{1, 2, 2};
    bit e2[3] = '{0, 0, 1};
    restart(1);
    for (int i = 0; i < s1.len(); i++) begin
      feed(1, s1[i]);
      n_tests++;
      if (int'(ib.depth) != d1[i] || ib.out !== o1[i] || ib.err !== 1'b0) begin
        n_fail++;
        $display("FAIL nest[%0d]: got depth=%0d out=%b err=%b want %0d/%b/0",
                 i, ib.depth, ib.out, ib.err, d1[i], o1[i]);
      end
    end
    restart(1);
    for (int i = 0; i < s2.len(); i++) begin
      feed(1, s2[i]);
      n_tests++;
      if (int'(ib.depth) != d2[i] || ib.err !== e2[i] || ib.out !== 1'b0) begin
        n_fail++;
        $display("FAIL nest_limit[%0d]: got depth=%0d err=%b want %0d/%b", i, ib.depth, ib.err,
                 d2[i], e2[i]);
      end
    end
  endtask

  task automatic test_illegal;
    string s2 = "1-2";
    string s3 = "1 + 2";
    string s4 = "(3)";
    bit e2[3] = '{0, 1, 1};
    bit e3[5] = '{0, 1, 1, 1, 1};
    restart(0);
    feed(0, ")");
    n_tests++;
    if (ia.err !== 1'b1 || ia.depth !== 3'd0) begin
      n_fail++; $display("FAIL close_at_zero: got err=%b depth=%0d want 1/0", ia.err, ia.depth);
    end
    restart(0);
    for (int i = 0; i < s2.len(); i++) begin
      feed(0, s2[i]);
      n_tests++;
      if (ia.err !== e2[i] || obs(0) !== mexp(0)) begin
        n_fail++; $display("FAIL disabled_op[%0d]: got err=%b want %b", i, ia.err, e2[i]);
      end
    end
    restart(1);
    for (int i = 0; i < s3.len(); i++) begin
      feed(1, s3[i]);
      n_tests++;
      if (ib.err !== e3[i] || obs(1) !== mexp(1)) begin
        n_fail++; $display("FAIL space_illegal[%0d]: got err=%b want %b", i, ib.err, e3[i]);
      end
    end
    for (int i = 0; i < s4.len(); i++) begin
      feed(1, s4[i]);
      n_tests++;
      if (ib.err !== 1'b1 || ib.out !== 1'b0) begin
        n_fail++; $display("FAIL sticky[%0d]: got err=%b out=%b want 1/0", i, ib.err, ib.out);
      end
    end
  endtask

  task automatic test_control;
    restart(0);
    feed(0, "1");
    drive(0, 1'b1, 1'b1, "7");
    n_tests++;
    if (obs(0) !== 10'd0) begin
      n_fail++; $display("FAIL restart_valid: got %h want 000", obs(0));
    end
    feed(0, "1");
    feed(0, "+");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b0, 1'b0, "9");
      n_tests++;
      if (obs(0) !== mexp(0) || ia.out !== 1'b0) begin
        n_fail++; $display("FAIL hold[%0d]: got %h want %h", i, obs(0), mexp(0));
      end
    end
    feed(0, "2");
    n_tests++;
    if (ia.out !== 1'b1 || ia.err !== 1'b0) begin
      n_fail++; $display("FAIL hold_resume: got out=%b err=%b want 1/0", ia.out, ia.err);
    end
  endtask

  task automatic test_async_reset;
    restart(0);
    feed(0, "(");
    feed(0, "1");
    n_tests++;
    if (ia.depth !== 3'd1 || ia.err !== 1'b0) begin
      n_fail++; $display("FAIL async_pre: got depth=%0d err=%b want 1/0", ia.depth, ia.err);
    end
    #2;
    clr = 1'b0;
    #1;
    mreset(0);
    mreset(1);
    n_tests++;
    if (obs(0) !== 10'd0) begin
      n_fail++; $display("FAIL async_clear: got %h want 000", obs(0));
    end
    #1;
    clr = 1'b1;
    feed(0, "5");
    n_tests++;
    if (ia.out !== 1'b1 || obs(0) !== mexp(0)) begin
      n_fail++; $display("FAIL async_after: got %h want %h", obs(0), mexp(0));
    end
  endtask

  task automatic test_random;
    string alph = "0123456789(()))+-*/ x";
    for (int w = 0; w < 2; w++) begin
      restart(w);
      for (int k = 0; k < 600; k++) begin
        int  r = $urandom_range(0, 99);
        byte c = alph[$urandom_range(0, alph.len() - 1)];
        if (r < 3 || (m_bad[w] && r < 25)) drive(w, 1'b1, r[0], c);
        else if (r < 12) drive(w, 1'b0, 1'b0, c);
        else feed(w, c);
        n_tests++;
        if (obs(w) !== mexp(w)) begin
          n_fail++; $display("FAIL random[%0d][%0d]: got %h want %h", w, k, obs(w), mexp(w));
        end
      end
    end
  endtask

  initial begin
    ia.restart = 1'b0; ia.in_valid = 1'b0; ia.in = 8'h00;
    ib.restart = 1'b0; ib.in_valid = 1'b0; ib.in = 8'h00;
    clr = 1'b0;
    test_reset();
    test_defaults();
    test_multidigit();
    test_nesting();
    test_illegal();
    test_control();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
